// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared constants and helpers for the regfile writeback arbiter
package rf_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NREG     = 2 ** ADDR_W;
    localparam int REG_ZERO = 0;

    // Low bit of slice idx in a flattened bus of w-bit fields.
    function automatic int slice_lo(input int idx, input int w);
        return idx * w;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - NREQ-wide round-robin arbiter with pointer register
//
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   req_valid   : per-requester pending request
//   grant       : one-hot grant (0 while rst_n is low)
//   grant_idx   : binary index of the granted requester
//   grant_any   : a grant (and therefore a handshake) happens this cycle
module rr_arbiter #(
    parameter int NREQ = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           grant,
    output logic [$clog2(NREQ)-1:0]   grant_idx,
    output logic                      grant_any
);

    localparam int PTR_W = $clog2(NREQ);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    // Search from the pointer upward, wrapping modulo NREQ; the first valid
    // requester wins. Any grant lands on a valid requester, so every grant is
    // a completed handshake.
    always_comb begin
        int idx;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        ptr_d     = ptr_q;
        idx       = 0;
        for (int off = 0; off < NREQ; off++) begin
            idx = int'(ptr_q) + off;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!grant_any && req_valid[idx]) begin
                grant_any  = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = PTR_W'(idx);
                ptr_d      = (idx == NREQ - 1) ? '0 : PTR_W'(idx + 1);
            end
        end
        if (!rst_n) begin
            grant     = '0;
            grant_any = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (grant_any) begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin sharing of the regfile write port with busy scoreboard
//
// Optional feature macro: WB_FWD_EN (same-cycle write-through forwarding ports)
//
// Ports:
//   clk, rst_n             : clock, synchronous active-low reset
//   req_valid / req_ready  : per-requester writeback handshake (ready is one-hot)
//   req_addr / req_data    : flattened destination/data, requester i in slice i
//   claim_valid/claim_addr : issue stage reserves a destination register
//   busy                   : per-register outstanding-write flags
//   rf_we / rf_rw / rf_w   : registered regfile write port
//   rd_addr_a/b, rf_a/b, fwd_a/b : forwarding read ports (WB_FWD_EN only)
module regfile_wb_arbiter
    import rf_pkg::*;
#(
    parameter int DATA_W = rf_pkg::DATA_W,
    parameter int ADDR_W = rf_pkg::ADDR_W,
    parameter int NREQ   = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    input  logic                     claim_valid,
    input  logic [ADDR_W-1:0]        claim_addr,
    output logic [2**ADDR_W-1:0]     busy,
`ifdef WB_FWD_EN
    input  logic [ADDR_W-1:0]        rd_addr_a,
    input  logic [ADDR_W-1:0]        rd_addr_b,
    input  logic [DATA_W-1:0]        rf_a,
    input  logic [DATA_W-1:0]        rf_b,
    output logic [DATA_W-1:0]        fwd_a,
    output logic [DATA_W-1:0]        fwd_b,
`endif
    output logic                     rf_we,
    output logic [ADDR_W-1:0]        rf_rw,
    output logic [DATA_W-1:0]        rf_w
);

    localparam int NREG_L = 2 ** ADDR_W;
    localparam int PTR_W  = $clog2(NREQ);
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

    logic [PTR_W-1:0]  grant_idx;
    logic              hs;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_data;
    logic [NREG_L-1:0] busy_d;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .grant     (req_ready),
        .grant_idx (grant_idx),
        .grant_any (hs)
    );

    always_comb begin
        win_addr = req_addr[slice_lo(int'(grant_idx), ADDR_W) +: ADDR_W];
        win_data = req_data[slice_lo(int'(grant_idx), DATA_W) +: DATA_W];
    end

    // A write to r0 still consumes the handshake but never asserts the enable,
    // so r0 keeps reading zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rf_we <= 1'b0;
            rf_rw <= '0;
            rf_w  <= '0;
        end else if (hs) begin
            rf_we <= (win_addr != ZERO_ADDR);
            rf_rw <= win_addr;
            rf_w  <= win_data;
        end else begin
            rf_we <= 1'b0;
        end
    end

    // Clear first, then set: a claim landing on the register being written
    // this cycle belongs to a newer instruction and must survive.
    always_comb begin
        busy_d = busy;
        if (rf_we) begin
            busy_d[rf_rw] = 1'b0;
        end
        if (claim_valid && (claim_addr != ZERO_ADDR)) begin
            busy_d[claim_addr] = 1'b1;
        end
        busy_d[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_d;
        end
    end

`ifdef WB_FWD_EN
    assign fwd_a = (rf_we && (rf_rw == rd_addr_a) && (rd_addr_a != ZERO_ADDR)) ? rf_w : rf_a;
    assign fwd_b = (rf_we && (rf_rw == rd_addr_b) && (rd_addr_b != ZERO_ADDR)) ? rf_w : rf_b;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

    typedef struct packed {
        logic        we;
        logic [4:0]  rw;
        logic [31:0] w;
    } wr_t;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [4:0]  a0, a1;
    logic [31:0] d0, d1;
    logic [9:0]  req_addr;
    logic [63:0] req_data;
    logic        claim_valid;
    logic [4:0]  claim_addr;
    logic [31:0] busy;
    logic        rf_we;
    logic [4:0]  rf_rw;
    logic [31:0] rf_w;
    logic [4:0]  rd_addr_a, rd_addr_b;
    logic [31:0] rf_a, rf_b;
`ifdef WB_FWD_EN
    logic [31:0] fwd_a, fwd_b;
`endif

    logic [31:0] tb_rf [32];

    int          tests;
    int          fails;
    int          m_ptr;
    logic [31:0] m_busy;
    wr_t         q[$];
    logic [1:0]  obs_ready;
    logic [31:0] obs_rf_a;
    logic [31:0] obs_busy;

    assign req_addr = {a1, a0};
    assign req_data = {d1, d0};
    assign rf_a     = tb_rf[rd_addr_a];
    assign rf_b     = tb_rf[rd_addr_b];

    regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .NREQ(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .claim_valid (claim_valid),
        .claim_addr  (claim_addr),
        .busy        (busy),
`ifdef WB_FWD_EN
        .rd_addr_a   (rd_addr_a),
        .rd_addr_b   (rd_addr_b),
        .rf_a        (rf_a),
        .rf_b        (rf_b),
        .fwd_a       (fwd_a),
        .fwd_b       (fwd_b),
`endif
        .rf_we       (rf_we),
        .rf_rw       (rf_rw),
        .rf_w        (rf_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in regfile driven by the DUT write port.
    always @(posedge clk) begin
        if (rf_we) tb_rf[rf_rw] <= rf_w;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] mgrant(input logic [1:0] v, input int p);
        for (int off = 0; off < 2; off++) begin
            int idx;
            idx = (p + off) % 2;
            if (v[idx]) return 2'(1 << idx);
        end
        return 2'b00;
    endfunction

    // One clock: check at the falling edge, update models at the rising edge,
    // leave inputs free to change 1 time unit after it.
    task automatic cycle();
        wr_t        e;
        logic [1:0] g;
        @(negedge clk);
        if (q.size() > 0) e = q.pop_front();
        else              e = '0;
        g = rst_n ? mgrant(req_valid, m_ptr) : 2'b00;
        chk("req_ready", {30'd0, req_ready}, {30'd0, g});
        chk("rf_we", {31'd0, rf_we}, {31'd0, e.we});
        if (e.we) begin
            chk("rf_rw", {27'd0, rf_rw}, {27'd0, e.rw});
            chk("rf_w", rf_w, e.w);
        end
        chk("busy", busy, m_busy);
`ifdef WB_FWD_EN
        chk("fwd_a", fwd_a, (e.we && e.rw == rd_addr_a && rd_addr_a != 0) ? e.w : tb_rf[rd_addr_a]);
        chk("fwd_b", fwd_b, (e.we && e.rw == rd_addr_b && rd_addr_b != 0) ? e.w : tb_rf[rd_addr_b]);
`endif
        obs_ready = req_ready;
        obs_rf_a  = rf_a;
        obs_busy  = busy;
        @(posedge clk);
        if (!rst_n) begin
            m_ptr  = 0;
            m_busy = '0;
            q.delete();
        end else begin
            if (e.we) m_busy[e.rw] = 1'b0;
            if (claim_valid && claim_addr != 0) m_busy[claim_addr] = 1'b1;
            if (g == 2'b01) begin
                q.push_back('{we: (a0 != 0), rw: a0, w: d0});
                m_ptr = 1;
            end else if (g == 2'b10) begin
                q.push_back('{we: (a1 != 0), rw: a1, w: d1});
                m_ptr = 0;
            end
        end
        #1;
    endtask

    initial begin
        logic [1:0] exp_g [6];
        exp_g = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
        tests = 0;
        fails = 0;
        m_ptr = 0;
        m_busy = '0;
        for (int r = 0; r < 32; r++) tb_rf[r] = '0;

        // Reset with both requesters pending.
        rst_n = 1'b0; req_valid = 2'b11; claim_valid = 1'b0; claim_addr = '0;
        a0 = 5'd4; d0 = 32'h4444_4444; a1 = 5'd3; d1 = 32'h3333_3333;
        rd_addr_a = 5'd1; rd_addr_b = 5'd5;
        @(posedge clk); #1;
        cycle();
        chk("rst_ready", {30'd0, obs_ready}, 32'd0);
        cycle();
        rst_n = 1'b1;
        cycle();
        chk("first_grant", {30'd0, obs_ready}, 32'd1);

        // Single write.
        a0 = 5'd1; d0 = 32'hffff_ffff; req_valid = 2'b01;
        cycle();
        chk("single_grant", {30'd0, obs_ready}, 32'd1);
        req_valid = 2'b00;
        cycle();
        cycle();
        chk("rf_a_r1", obs_rf_a, 32'hffff_ffff);

        // Bring the pointer back to requester 0.
        req_valid = 2'b10;
        cycle();

        // Contention.
        a0 = 5'd1; d0 = 32'h1111_1111; a1 = 5'd2; d1 = 32'h8888_8888;
        req_valid = 2'b11; rd_addr_a = 5'd2;
        for (int i = 0; i < 6; i++) begin
            cycle();
            chk("contend_grant", {30'd0, obs_ready}, {30'd0, exp_g[i]});
            chk("contend_rf_a", obs_rf_a, (i >= 3) ? 32'h8888_8888 : 32'h0);
        end
        req_valid = 2'b00;
        cycle();

        // Register zero.
        a0 = 5'd0; d0 = 32'hdead_beef; req_valid = 2'b01; rd_addr_a = 5'd0;
        cycle();
        req_valid = 2'b00;
        cycle();
        claim_valid = 1'b1; claim_addr = 5'd0;
        cycle();
        claim_valid = 1'b0;
        cycle();
        chk("r0_read", obs_rf_a, 32'h0);
        chk("busy0", {31'd0, obs_busy[0]}, 32'd0);

        // Scoreboard set, clear, and set-wins-over-clear.
        claim_valid = 1'b1; claim_addr = 5'd5;
        cycle();
        claim_valid = 1'b0; a1 = 5'd5; d1 = 32'h5555_5555; req_valid = 2'b10;
        cycle();
        chk("busy5_set", {31'd0, obs_busy[5]}, 32'd1);
        req_valid = 2'b00;
        cycle();
        cycle();
        chk("busy5_clr", {31'd0, obs_busy[5]}, 32'd0);
        claim_valid = 1'b1; claim_addr = 5'd5;
        cycle();
        claim_valid = 1'b0; d1 = 32'h5a5a_5a5a; req_valid = 2'b10;
        cycle();
        req_valid = 2'b00; claim_valid = 1'b1; claim_addr = 5'd5;
        cycle();
        claim_valid = 1'b0;
        cycle();
        chk("busy5_setwins", {31'd0, obs_busy[5]}, 32'd1);
        cycle();
        cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
